// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolver with a direct-mapped 2-bit BHT and saturating statistics.
// Resolves the six RV64I conditional branches and registers the outcome one cycle later.
module branch_resolve_predict #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned IDX_LSB     = 2,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_kill,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic              ex_pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic              res_illegal,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IdxW = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [IdxW-1:0]   if_idx;
  logic [IdxW-1:0]   ex_idx;

  logic              acc;
  logic              rs_eq;
  logic              rs_lt_s;
  logic              rs_lt_u;
  logic              cond_taken;
  logic              cond_illegal;
  logic              cond_mispredict;
  logic              bht_upd;
  logic [1:0]        ctr_cur;
  logic [1:0]        ctr_d;

  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic              res_misp_q, res_misp_d;
  logic              res_ill_q, res_ill_d;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

  // Only the index slice of each PC matters; the rest is aliased by design.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc};

  assign if_idx = if_pc[IDX_LSB +: IdxW];
  assign ex_idx = ex_pc[IDX_LSB +: IdxW];

  // Read port shows the registered counter; a same-cycle update is not bypassed.
  assign if_pred_taken = bht_q[if_idx][1];

  assign acc     = ex_valid & ~ex_kill;
  assign rs_eq   = (ex_rs1 == ex_rs2);
  assign rs_lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
  assign rs_lt_u = (ex_rs1 < ex_rs2);

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    unique case (ex_funct3)
      3'b000:  cond_taken = rs_eq;
      3'b001:  cond_taken = ~rs_eq;
      3'b100:  cond_taken = rs_lt_s;
      3'b101:  cond_taken = ~rs_lt_s;
      3'b110:  cond_taken = rs_lt_u;
      3'b111:  cond_taken = ~rs_lt_u;
      default: cond_illegal = 1'b1;
    endcase
  end

  assign cond_mispredict = cond_taken ^ ex_pred_taken;
  assign bht_upd         = acc & ~cond_illegal;

  always_comb begin
    ctr_cur = bht_q[ex_idx];
    ctr_d   = ctr_cur;
    if (cond_taken) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    res_valid_d = acc;
    res_taken_d = acc & cond_taken;
    res_misp_d  = acc & cond_mispredict;
    res_ill_d   = acc & cond_illegal;

    stat_br_d = stat_br_q;
    if (bht_upd && (stat_br_q != '1)) begin
      stat_br_d = stat_br_q + STAT_W'(1);
    end

    stat_mp_d = stat_mp_q;
    if (acc && cond_mispredict && (stat_mp_q != '1)) begin
      stat_mp_d = stat_mp_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_misp_q  <= 1'b0;
      res_ill_q   <= 1'b0;
      stat_br_q   <= '0;
      stat_mp_q   <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      res_misp_q  <= res_misp_d;
      res_ill_q   <= res_ill_d;
      stat_br_q   <= stat_br_d;
      stat_mp_q   <= stat_mp_d;
    end
  end

  // Reset takes priority, so a resolve in the reset cycle never touches the table.
  always_ff @(posedge clk) begin
    if (reset) begin
      bht_q <= '{default: 2'b01};
    end else if (bht_upd) begin
      bht_q[ex_idx] <= ctr_d;
    end
  end

  assign res_valid        = res_valid_q;
  assign res_taken        = res_taken_q;
  assign res_mispredict   = res_misp_q;
  assign res_illegal      = res_ill_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: vector table for the compares plus
// hand sequences for BHT saturation, collision, kill/illegal, reset and stat saturation.
module tb_branch_resolve_predict;

  logic        clk;
  logic        reset;
  logic [63:0] if_pc;
  logic        ex_valid;
  logic        ex_kill;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_pc;
  logic [63:0] ex_rs1;
  logic [63:0] ex_rs2;
  logic        ex_pred_taken;

  logic        if_pred_taken;
  logic        res_valid, res_taken, res_mispredict, res_illegal;
  logic [31:0] stat_branches, stat_mispredicts;

  logic        s_if_pred_taken;
  logic        s_res_valid, s_res_taken, s_res_mispredict, s_res_illegal;
  logic [3:0]  s_stat_branches, s_stat_mispredicts;

  int n_cmp;
  int n_fail;
  int exp_br;
  int exp_mp;

  branch_resolve_predict #(
    .XLEN(64), .BHT_ENTRIES(16), .IDX_LSB(2), .STAT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_kill(ex_kill), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_illegal(res_illegal), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  branch_resolve_predict #(
    .XLEN(64), .BHT_ENTRIES(16), .IDX_LSB(2), .STAT_W(4)
  ) dut_small (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(s_if_pred_taken),
    .ex_valid(ex_valid), .ex_kill(ex_kill), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_mispredict(s_res_mispredict),
    .res_illegal(s_res_illegal), .stat_branches(s_stat_branches),
    .stat_mispredicts(s_stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        pred;
    logic        taken;
    logic        misp;
    logic        ill;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic k, input logic [2:0] f3,
                       input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                       input logic p);
    ex_valid      = v;
    ex_kill       = k;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pred_taken = p;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_br = 0;
    exp_mp = 0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_br = 0;
    exp_mp = 0;
    reset  = 1'b1;
    if_pc  = 64'h0;
    idle();

    //              f3      rs1                     rs2                     pred tk mp il
    vecs[0]  = '{3'b000, 64'd5,                  64'd5,                  1'b1, 1, 0, 0};
    vecs[1]  = '{3'b000, 64'd5,                  64'd6,                  1'b0, 0, 0, 0};
    vecs[2]  = '{3'b001, 64'd5,                  64'd6,                  1'b0, 1, 1, 0};
    vecs[3]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 1'b0, 1, 1, 0};
    vecs[4]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 1'b1, 0, 1, 0};
    vecs[5]  = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 1'b0, 0, 0, 0};
    vecs[6]  = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 1'b1, 1, 0, 0};
    vecs[7]  = '{3'b100, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 0};
    vecs[8]  = '{3'b101, 64'd7,                  64'd7,                  1'b1, 1, 0, 0};
    vecs[9]  = '{3'b110, 64'd0,                  64'd1,                  1'b0, 1, 1, 0};
    vecs[10] = '{3'b111, 64'd3,                  64'd3,                  1'b0, 1, 1, 0};
    vecs[11] = '{3'b101, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0, 1, 0};
    vecs[12] = '{3'b011, 64'd9,                  64'd9,                  1'b0, 0, 0, 1};

    // Reset and idle
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst res_taken", {63'd0, res_taken}, 64'd0);
    chk("rst res_mispredict", {63'd0, res_mispredict}, 64'd0);
    chk("rst res_illegal", {63'd0, res_illegal}, 64'd0);
    chk("rst stat_branches", {32'd0, stat_branches}, 64'd0);
    chk("rst stat_mispredicts", {32'd0, stat_mispredicts}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      if_pc = 64'(i) << 2;
      #1;
      chk($sformatf("rst if_pred idx%0d", i), {63'd0, if_pred_taken}, 64'd0);
    end

    // Compare table, one accept per vector, result checked one cycle later
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b0, vecs[i].f3, 64'h1000 + 64'(i) * 4, vecs[i].rs1, vecs[i].rs2,
            vecs[i].pred);
      tick();
      chk($sformatf("vec%0d res_valid", i), {63'd0, res_valid}, 64'd1);
      chk($sformatf("vec%0d res_taken", i), {63'd0, res_taken}, {63'd0, vecs[i].taken});
      chk($sformatf("vec%0d res_mispredict", i), {63'd0, res_mispredict},
          {63'd0, vecs[i].misp});
      chk($sformatf("vec%0d res_illegal", i), {63'd0, res_illegal}, {63'd0, vecs[i].ill});
      if (!vecs[i].ill) exp_br++;
      if (vecs[i].misp) exp_mp++;
    end
    idle();
    tick();
    chk("idle res_valid", {63'd0, res_valid}, 64'd0);
    chk("idle res_taken", {63'd0, res_taken}, 64'd0);
    chk("idle res_illegal", {63'd0, res_illegal}, 64'd0);
    chk("vec stat_branches", {32'd0, stat_branches}, 64'(exp_br));
    chk("vec stat_mispredicts", {32'd0, stat_mispredicts}, 64'(exp_mp));

    // Counter saturation at pc 0x40
    do_reset();
    chk("rst2 stat_branches", {32'd0, stat_branches}, 64'd0);
    if_pc = 64'h40;
    #1;
    chk("sat initial pred", {63'd0, if_pred_taken}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'b000, 64'h40, 64'd3, 64'd3, 1'b0);
      tick();
      chk($sformatf("sat%0d res_mispredict", i), {63'd0, res_mispredict}, 64'd1);
      chk($sformatf("sat%0d if_pred", i), {63'd0, if_pred_taken}, 64'd1);
    end
    drive(1'b1, 1'b0, 3'b000, 64'h40, 64'd3, 64'd4, 1'b1);
    tick();
    chk("sat nt1 res_mispredict", {63'd0, res_mispredict}, 64'd1);
    chk("sat nt1 if_pred (ctr 10)", {63'd0, if_pred_taken}, 64'd1);
    drive(1'b1, 1'b0, 3'b000, 64'h40, 64'd3, 64'd4, 1'b1);
    tick();
    chk("sat nt2 if_pred (ctr 01)", {63'd0, if_pred_taken}, 64'd0);

    // Read/update collision at pc 0x10, no bypass
    if_pc = 64'h10;
    drive(1'b1, 1'b0, 3'b001, 64'h10, 64'd1, 64'd2, 1'b0);
    #1;
    chk("collide pre-update pred", {63'd0, if_pred_taken}, 64'd0);
    tick();
    chk("collide post-update pred", {63'd0, if_pred_taken}, 64'd1);
    idle();
    tick();

    // Kill and illegal at pc 0x20
    do_reset();
    if_pc = 64'h20;
    drive(1'b1, 1'b1, 3'b000, 64'h20, 64'd8, 64'd8, 1'b0);
    tick();
    chk("kill res_valid", {63'd0, res_valid}, 64'd0);
    chk("kill res_mispredict", {63'd0, res_mispredict}, 64'd0);
    tick();
    chk("kill if_pred", {63'd0, if_pred_taken}, 64'd0);
    chk("kill stat_branches", {32'd0, stat_branches}, 64'd0);
    chk("kill stat_mispredicts", {32'd0, stat_mispredicts}, 64'd0);
    drive(1'b1, 1'b0, 3'b010, 64'h20, 64'd8, 64'd8, 1'b1);
    tick();
    chk("illegal res_valid", {63'd0, res_valid}, 64'd1);
    chk("illegal res_taken", {63'd0, res_taken}, 64'd0);
    chk("illegal res_illegal", {63'd0, res_illegal}, 64'd1);
    chk("illegal res_mispredict", {63'd0, res_mispredict}, 64'd1);
    chk("illegal stat_branches", {32'd0, stat_branches}, 64'd0);
    chk("illegal stat_mispredicts", {32'd0, stat_mispredicts}, 64'd1);
    // Counter must still be 01: one taken update lands on 10
    drive(1'b1, 1'b0, 3'b000, 64'h20, 64'd8, 64'd8, 1'b1);
    tick();
    chk("post-illegal if_pred", {63'd0, if_pred_taken}, 64'd1);
    chk("post-illegal stat_branches", {32'd0, stat_branches}, 64'd1);

    // Reset during a valid resolve wins
    if_pc = 64'h30;
    drive(1'b1, 1'b0, 3'b000, 64'h30, 64'd2, 64'd2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("midrst if_pred", {63'd0, if_pred_taken}, 64'd0);
    chk("midrst res_valid", {63'd0, res_valid}, 64'd0);
    chk("midrst stat_branches", {32'd0, stat_branches}, 64'd0);
    chk("midrst stat_mispredicts", {32'd0, stat_mispredicts}, 64'd0);
    tick();
    chk("midrst+1 res_valid", {63'd0, res_valid}, 64'd0);

    // 20 back-to-back mispredicted branches: 32-bit stats reach 20, 4-bit stats hold at 15
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 3'b000, 64'h44, 64'd1, 64'd1, 1'b0);
      tick();
      chk($sformatf("b2b%0d res_valid", i), {63'd0, res_valid}, 64'd1);
    end
    idle();
    tick();
    chk("b2b stat_branches", {32'd0, stat_branches}, 64'd20);
    chk("b2b stat_mispredicts", {32'd0, stat_mispredicts}, 64'd20);
    chk("sat4 stat_branches", {60'd0, s_stat_branches}, 64'd15);
    chk("sat4 stat_mispredicts", {60'd0, s_stat_mispredicts}, 64'd15);
    tick();
    chk("sat4 hold stat_branches", {60'd0, s_stat_branches}, 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
Parametrised successor to the EX-stage branch comparator. It resolves all six RV64I conditional branches, with signed and unsigned compares, and registers the outcome. It also owns a direct-mapped table of 2-bit saturating counters (BHT), which the IF stage reads for predictions. On each resolve it raises a one-cycle mispredict flag for the hazard/flush logic and keeps saturating branch and mispredict statistics.

Parameters:
XLEN, 64, operand width in bits
BHT_ENTRIES, 16, number of BHT counters; power of 2, minimum 2
IDX_LSB, 2, lowest PC bit used for the BHT index; index = pc[IDX_LSB +: log2(BHT_ENTRIES)]
STAT_W, 32, width of each statistics counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
if_pc  in  XLEN  PC of the instruction being fetched
if_pred_taken  out  1  combinational prediction; counter[idx(if_pc)][1]
ex_valid  in  1  a branch instruction is in EX this cycle
ex_kill  in  1  EX instruction is squashed; overrides ex_valid
ex_funct3  in  3  branch funct3
ex_pc  in  XLEN  PC of the EX branch
ex_rs1  in  XLEN  forwarded operand 1
ex_rs2  in  XLEN  forwarded operand 2
ex_pred_taken  in  1  prediction carried down the pipe with this branch
res_valid  out  1  registered: a resolve happened last cycle
res_taken  out  1  registered actual outcome
res_mispredict  out  1  registered: res_taken != ex_pred_taken
res_illegal  out  1  registered: funct3 was 010 or 011
stat_branches  out  STAT_W  count of resolved legal branches, saturating
stat_mispredicts  out  STAT_W  count of mispredicts, saturating

Behaviour:
- Reset (sync, active-high):
  - all res_* outputs go to 0; both stats go to 0.
  - every BHT counter goes to 2'b01 (weakly not-taken).
  - reset wins over a same-cycle resolve; no BHT update and no stats update occur.
- Accept condition: acc = ex_valid & ~ex_kill.
- Condition decode by ex_funct3:
  - 000 beq: rs1 == rs2
  - 001 bne: rs1 != rs2
  - 100 blt: signed rs1 < rs2
  - 101 bge: signed rs1 >= rs2
  - 110 bltu: unsigned rs1 < rs2
  - 111 bgeu: unsigned rs1 >= rs2
  - 010 and 011: taken = 0, illegal = 1.
  - The compare is purely combinational; signedness is applied explicitly at full XLEN.
- Latency: an EX instruction accepted in cycle N produces res_* in cycle N+1.
  - Outputs are valid for exactly one cycle.
  - res_valid = 0 in any cycle following a non-accept; res_taken, res_mispredict and res_illegal are then 0.
- res_mispredict is computed as taken ^ ex_pred_taken.
  - For an illegal funct3: res_mispredict = ex_pred_taken, res_illegal = 1.
- BHT update, on the same edge that registers res_*, only for acc and a legal funct3:
  - at index idx(ex_pc): taken → counter +1, saturating at 11; not-taken → counter −1, saturating at 00.
  - Illegal or killed instructions leave the BHT untouched.
- Read/update collision: if idx(if_pc) == idx(ex_pc) in the same cycle, if_pred_taken shows the pre-update value. There is no bypass.
- Index aliasing is permitted; PCs that differ only above the index bits share a counter.
- Statistics:
  - stat_branches increments on acc with a legal funct3.
  - stat_mispredicts increments on acc with res_mispredict true, illegal included.
  - Both saturate at all-ones and never wrap.
- Back-to-back accepts every cycle are supported at full throughput, including repeated updates to the same index.
- No internal stall. The pipeline deasserts ex_valid while EX is stalled.

Test Plan:
- Reset then idle: all res_* = 0, both stats = 0; if_pred_taken = 0 for all 16 indices.
- Signedness: rs1 = 64'hFFFF_FFFF_FFFF_FFFF, rs2 = 1 → blt: res_taken = 1; bltu: res_taken = 0; bge: 0; bgeu: 1. Result appears one cycle after acc.
- Counter saturation: ex_pc = 0x40, four taken beq with pred 0. Counter goes 01→10→11→11; if_pred_taken(0x40) becomes 1 after the first update; res_mispredict = 1,1,1,1. A following not-taken resolve gives counter 10, and if_pred_taken stays 1.
- Collision: resolve taken at pc 0x10 while if_pc = 0x10 (counter 01) → if_pred_taken = 0 that cycle and 1 the next cycle.
- Kill and illegal: ex_valid = 1 with ex_kill = 1 → res_valid = 0 and no BHT or stats change. funct3 = 010 with pred 1 → res_illegal = 1, res_mispredict = 1, stat_mispredicts +1, stat_branches unchanged.
- Reset mid-operation and saturation: assert reset during a valid resolve → no update and stats = 0. Separately, with STAT_W = 4, resolve 20 branches → stat_branches holds at 15.
